atmega_clk_mon: RTL and testbench



---
 rtl/atmega_clk_mon.sv | 172 +++++++++++++++++
 tb/tb_atmega_clk_mon.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_clk_mon.sv
// Clock monitor: counts synchronized rising edges of ck_in over a programmable
// window of clk cycles and reports the count plus a LOCK (stable frequency) flag.
module atmega_clk_mon #(
    parameter int                           BUS_ADDR_DATA_LEN = 16,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] CMCSR_ADDR        = 'h3A,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] CMCNTL_ADDR       = 'h3B,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] CMCNTH_ADDR       = 'h3C,
    parameter int                           TOL               = 2
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    input  logic                         ck_in,
    output logic                         irq
);

    // state | meaning
    // IDLE  | no measurement, waits for EN
    // ARM   | waits for the first ck_in edge (not counted), times out after N cycles
    // COUNT | counts ck_in edges for exactly N clk cycles
    // LATCH | publishes result, updates LOCK, rearms or stops
    typedef enum logic [1:0] {IDLE, ARM, COUNT, LATCH} state_t;

    state_t      state, state_nxt;
    logic        load, latch;
    logic        en, cont, ie, done, lock, lock_nxt;
    logic [1:0]  win, win_act;
    logic [13:0] wcnt;
    logic [15:0] cnt, result, prev, diff;
    logic [7:0]  temp;
    logic        s1, s2, s3, rise;
    logic        busy, csr_wr, abort, cntl_rd;
    logic        unused_bus_bits;

    function automatic logic [13:0] win_last(input logic [1:0] w);
        case (w)
            2'd0:    win_last = 14'd255;
            2'd1:    win_last = 14'd1023;
            2'd2:    win_last = 14'd4095;
            default: win_last = 14'd16383;
        endcase
    endfunction

    assign rise            = s2 & ~s3;
    assign busy            = (state != IDLE);
    assign csr_wr          = wr && (addr == CMCSR_ADDR);
    assign abort           = csr_wr && !bus_in[0] && busy;
    assign cntl_rd         = rd && (addr == CMCNTL_ADDR);
    assign irq             = done & ie;
    assign unused_bus_bits = ^bus_in[6:5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = ARM;
                    load      = 1'b1;
                end
            end
            ARM: begin
                if (rise)              state_nxt = COUNT;
                else if (wcnt == '0)   state_nxt = LATCH;
            end
            COUNT: begin
                if (wcnt == '0) state_nxt = LATCH;
            end
            LATCH: begin
                latch = 1'b1;
                if (cont) begin
                    state_nxt = ARM;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Firmware abort overrides whatever the window was about to do.
        if (abort) begin
            state_nxt = IDLE;
            load      = 1'b0;
            latch     = 1'b0;
        end
    end

    always_comb begin
        diff     = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
        lock_nxt = (cnt != '0) && (prev != '0) && (diff <= 16'(TOL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            en      <= 1'b0;
            cont    <= 1'b0;
            win     <= 2'd0;
            ie      <= 1'b0;
            done    <= 1'b0;
            lock    <= 1'b0;
            win_act <= 2'd0;
            wcnt    <= '0;
            cnt     <= '0;
            result  <= '0;
            prev    <= '0;
            temp    <= '0;
        end else begin
            s1 <= ck_in;
            s2 <= s1;
            s3 <= s2;

            if (load) begin
                win_act <= win;
                wcnt    <= win_last(win);
                cnt     <= '0;
            end else if (state == ARM) begin
                if (rise)            wcnt <= win_last(win_act);
                else if (wcnt != '0) wcnt <= wcnt - 14'd1;
            end else if (state == COUNT) begin
                if (wcnt != '0) wcnt <= wcnt - 14'd1;
                if (rise)       cnt  <= cnt + 16'd1;
            end

            if (csr_wr) begin
                en   <= bus_in[0];
                cont <= bus_in[1];
                win  <= bus_in[3:2];
                ie   <= bus_in[7];
                if (bus_in[4]) done <= 1'b0;
            end

            // Hardware set of DONE and self-clear of EN take priority over a same-cycle write.
            if (latch) begin
                result <= cnt;
                done   <= 1'b1;
                lock   <= lock_nxt;
                prev   <= cnt;
                if (!cont) en <= 1'b0;
            end

            if (abort) begin
                lock <= 1'b0;
                prev <= '0;
            end

            if (cntl_rd) temp <= result[15:8];
        end
    end

    always_comb begin
        bus_out = 8'h00;
        if (!rst && rd) begin
            if (addr == CMCSR_ADDR)       bus_out = {ie, busy, lock, done, win, cont, en};
            else if (addr == CMCNTL_ADDR) bus_out = result[7:0];
            else if (addr == CMCNTH_ADDR) bus_out = temp;
        end
    end

endmodule

// File: tb/tb_atmega_clk_mon.sv
// Bench for atmega_clk_mon: register reads are scored against a queue of
// expectations derived from a window/edge-count model of the monitor.
module tb_atmega_clk_mon;

    localparam logic [15:0] A_CSR  = 16'h3A;
    localparam logic [15:0] A_CNTL = 16'h3B;
    localparam logic [15:0] A_CNTH = 16'h3C;
    localparam int          TOL    = 2;

    logic        clk = 1'b0;
    logic        rst, wr, rd, ck_in;
    logic [15:0] addr;
    logic [7:0]  bus_in, bus_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int ck_per = 0;
    int ph     = 0;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] mask;
        bit         irq_chk;
        logic       irq_exp;
    } exp_t;
    exp_t sb[$];

    int m_prev_lo = 0;
    int m_prev_hi = 0;

    atmega_clk_mon #(
        .BUS_ADDR_DATA_LEN(16),
        .CMCSR_ADDR       (16'h3A),
        .CMCNTL_ADDR      (16'h3B),
        .CMCNTH_ADDR      (16'h3C),
        .TOL              (TOL)
    ) dut (
        .rst    (rst),
        .clk    (clk),
        .addr   (addr),
        .wr     (wr),
        .rd     (rd),
        .bus_in (bus_in),
        .bus_out(bus_out),
        .ck_in  (ck_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // ck_in: one rising edge every ck_per clk cycles, changing off the clk edge
    initial begin
        ck_in = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (ck_per == 0) begin
                ph    = 0;
                ck_in = 1'b0;
            end else begin
                ph    = (ph + 1) % ck_per;
                ck_in = (ph < ck_per / 2);
            end
        end
    end

    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (rd) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: bus_out=%h with no expectation queued", bus_out);
                end else begin
                    e   = sb.pop_front();
                    got = bus_out & e.mask;
                    if (got != (e.a & e.mask) && got != (e.b & e.mask)) begin
                        errors++;
                        $display("FAIL %s: bus_out=%h (mask %h) expected %h or %h",
                                 e.name, bus_out, e.mask, e.a, e.b);
                    end
                    if (e.irq_chk) begin
                        checks++;
                        if (irq !== e.irq_exp) begin
                            errors++;
                            $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    function automatic int n_of(input int w);
        return 256 << (2 * w);
    endfunction

    function automatic logic [7:0] csr_v(input bit ie, input bit busy, input bit lk,
                                         input bit dn, input int w, input bit ct, input bit en);
        return {ie, busy, lk, dn, 2'(w), ct, en};
    endfunction

    // LOCK expectation from the possible result/previous-result intervals
    task automatic model_window(input int lo, input int hi, output logic lk, output logic [7:0] msk);
        int mind, maxd;
        maxd = (hi - m_prev_lo > m_prev_hi - lo) ? hi - m_prev_lo : m_prev_hi - lo;
        if (lo > m_prev_hi)      mind = lo - m_prev_hi;
        else if (m_prev_lo > hi) mind = m_prev_lo - hi;
        else                     mind = 0;
        msk = 8'hFF;
        if (hi == 0 || m_prev_hi == 0 || mind > TOL)          lk = 1'b0;
        else if (lo > 0 && m_prev_lo > 0 && maxd <= TOL)     lk = 1'b1;
        else begin
            lk  = 1'b0;
            msk = 8'hDF;
        end
        m_prev_lo = lo;
        m_prev_hi = hi;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [15:0] a, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [7:0] m, input bit ic, input logic iexp);
        exp_t e;
        e.name    = n;
        e.a       = ea;
        e.b       = eb;
        e.mask    = m;
        e.irq_chk = ic;
        e.irq_exp = iexp;
        sb.push_back(e);
        addr = a;
        rd   = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic rd_eq(input string n, input logic [15:0] a, input logic [7:0] v);
        rd_chk(n, a, v, v, 8'hFF, 1'b0, 1'b0);
    endtask

    task automatic rd_csr(input string n, input logic [7:0] v, input logic [7:0] m, input logic iexp);
        rd_chk(n, A_CSR, v, v, m, 1'b1, iexp);
    endtask

    task automatic wait_irq(input string n, input int budget, output int cyc);
        cyc = 0;
        while (irq !== 1'b1 && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (irq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: irq=%b after %0d cycles, expected 1", n, irq, budget);
        end
    endtask

    task automatic count_range(input int w, output int lo, output int hi);
        if (ck_per == 0) begin
            lo = 0;
            hi = 0;
        end else begin
            lo = n_of(w) / ck_per;
            hi = (n_of(w) + ck_per - 1) / ck_per;
        end
    endtask

    task automatic single_shot(input string n, input int w);
        int         lo, hi, cyc;
        logic       lk;
        logic [7:0] msk;
        count_range(w, lo, hi);
        wr_reg(A_CSR, 8'h81 | 8'(w << 2));
        wait_irq(n, 20000, cyc);
        model_window(lo, hi, lk, msk);
        rd_csr({n, "_csr"}, csr_v(1, 0, lk, 1, w, 0, 0), msk, 1'b1);
        rd_chk({n, "_cntl"}, A_CNTL, 8'(lo), 8'(hi), 8'hFF, 1'b0, 1'b0);
        rd_chk({n, "_cnth"}, A_CNTH, 8'(lo >> 8), 8'(hi >> 8), 8'hFF, 1'b0, 1'b0);
        wr_reg(A_CSR, 8'h90 | 8'(w << 2));
        rd_csr({n, "_clr"}, csr_v(1, 0, lk, 0, w, 0, 0), msk, 1'b0);
    endtask

    initial begin
        int         cyc, lo, hi, w, p;
        logic       lk;
        logic [7:0] msk;

        rst    = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        addr   = '0;
        bus_in = '0;
        ck_per = 4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        rd_csr("reset_csr", 8'h00, 8'hFF, 1'b0);
        rd_eq("reset_cntl", A_CNTL, 8'h00);
        rd_eq("reset_cnth", A_CNTH, 8'h00);

        single_shot("div4_win256", 0);

        // continuous mode, clk/4 for two windows then clk/6 for two
        wr_reg(A_CSR, 8'h87);
        for (int k = 0; k < 4; k++) begin
            wait_irq("cont_irq", 20000, cyc);
            if (k == 1) ck_per = 6;
            if (k < 2) begin
                lo = 256;
                hi = 256;
            end else begin
                lo = 170;
                hi = 171;
            end
            model_window(lo, hi, lk, msk);
            rd_csr($sformatf("cont%0d_csr", k), csr_v(1, 1, lk, 1, 1, 1, 1), msk, 1'b1);
            rd_chk($sformatf("cont%0d_cntl", k), A_CNTL, 8'(lo), 8'(hi), 8'hFF, 1'b0, 1'b0);
            rd_chk($sformatf("cont%0d_cnth", k), A_CNTH, 8'(lo >> 8), 8'(hi >> 8), 8'hFF, 1'b0, 1'b0);
            wr_reg(A_CSR, 8'h97);
            rd_csr($sformatf("cont%0d_clr", k), csr_v(1, 1, lk, 0, 1, 1, 1), msk, 1'b0);
        end

        // abort mid-window: BUSY drops, result kept, LOCK cleared
        repeat (100) @(posedge clk);
        #1;
        wr_reg(A_CSR, 8'h00);
        m_prev_lo = 0;
        m_prev_hi = 0;
        rd_csr("abort_csr", 8'h00, 8'hFF, 1'b0);
        rd_chk("abort_cntl", A_CNTL, 8'd170, 8'd171, 8'hFF, 1'b0, 1'b0);
        rd_eq("abort_cnth", A_CNTH, 8'h00);

        // ck_in idle: ARM times out after N cycles
        ck_per = 0;
        repeat (5) @(posedge clk);
        #1;
        wr_reg(A_CSR, 8'h81);
        wait_irq("idle_irq", 20000, cyc);
        checks++;
        if (cyc != 258) begin
            errors++;
            $display("FAIL idle_timeout_latency: irq after %0d cycles, expected 258", cyc);
        end
        model_window(0, 0, lk, msk);
        rd_csr("idle_csr", csr_v(1, 0, lk, 1, 0, 0, 0), msk, 1'b1);
        rd_eq("idle_cntl", A_CNTL, 8'h00);
        rd_eq("idle_cnth", A_CNTH, 8'h00);
        wr_reg(A_CSR, 8'h90);

        // DONE-clear landing on the LATCH edge: the set wins
        wr_reg(A_CSR, 8'h81);
        repeat (257) @(posedge clk);
        #1;
        wr_reg(A_CSR, 8'h91);
        model_window(0, 0, lk, msk);
        rd_csr("clr_vs_latch_csr", csr_v(1, 0, lk, 1, 0, 0, 0), 8'hB0 & msk, 1'b1);
        wr_reg(A_CSR, 8'h90);
        m_prev_lo = 0;
        m_prev_hi = 0;

        // 16-bit read coherence across a result update
        ck_per = 4;
        repeat (10) @(posedge clk);
        #1;
        wr_reg(A_CSR, 8'h85);
        wait_irq("r16_a_irq", 20000, cyc);
        model_window(256, 256, lk, msk);
        rd_csr("r16_a_csr", csr_v(1, 0, lk, 1, 1, 0, 0), msk, 1'b1);
        rd_eq("r16_a_cntl", A_CNTL, 8'h00);
        wr_reg(A_CSR, 8'h90);
        wr_reg(A_CSR, 8'h81);
        wait_irq("r16_b_irq", 20000, cyc);
        rd_eq("r16_stale_cnth", A_CNTH, 8'h01);
        rd_eq("r16_b_cntl", A_CNTL, 8'h40);
        rd_eq("r16_b_cnth", A_CNTH, 8'h00);
        model_window(64, 64, lk, msk);
        rd_csr("r16_b_csr", csr_v(1, 0, lk, 1, 0, 0, 0), msk, 1'b1);
        wr_reg(A_CSR, 8'h90);

        // reset in the middle of a window
        wr_reg(A_CSR, 8'h85);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        rd_csr("rst_busout", 8'h00, 8'hFF, 1'b0);
        rst = 1'b0;
        m_prev_lo = 0;
        m_prev_hi = 0;
        rd_csr("rst_csr", 8'h00, 8'hFF, 1'b0);
        rd_eq("rst_cntl", A_CNTL, 8'h00);
        rd_eq("rst_cnth", A_CNTH, 8'h00);

        // randomized frequency / window pairs
        for (int t = 0; t < 3; t++) begin
            p = $urandom_range(3, 12);
            w = $urandom_range(0, 1);
            wr_reg(A_CSR, 8'h81);
            repeat (3) @(posedge clk);
            #1;
            wr_reg(A_CSR, 8'h80);
            m_prev_lo = 0;
            m_prev_hi = 0;
            ck_per = p;
            repeat ($urandom_range(5, 20)) @(posedge clk);
            #1;
            single_shot($sformatf("rnd%0d_p%0d_w%0d_a", t, p, w), w);
            single_shot($sformatf("rnd%0d_p%0d_w%0d_b", t, p, w), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
